// File: rtl/soil_moisture_monitor_pkg.sv
// Shared types and seven-segment constants for the soil moisture monitor.
package soil_pkg;

    typedef enum logic [1:0] {OK, ALARM, ACKED} alarm_state_t;
    typedef enum logic {BLANK, SHOW} disp_state_t;

    // Segment bit order {dp,g,f,e,d,c,b,a}, active-high; digits never light dp.
    localparam logic [7:0] SEG_DIGIT [0:7] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07
    };
    localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/soil_moisture_monitor_if.sv
// Sensor/operator inputs and LED/display outputs of the soil moisture monitor.
interface soil_moisture_monitor_if #(
    parameter int NCH = 4
);
    localparam int CNTW = $clog2(NCH + 1);

    logic [NCH-1:0]  dry_in;
    logic            ack;
    logic [NCH-1:0]  dry_flags;
    logic [CNTW-1:0] dry_count;
    logic            alarm;
    logic [7:0]      seg;

    modport master (
        output dry_in, ack,
        input  dry_flags, dry_count, alarm, seg
    );

    modport slave (
        input  dry_in, ack,
        output dry_flags, dry_count, alarm, seg
    );
endinterface

// File: rtl/soil_moisture_monitor_filter.sv
// One-channel persistence filter: the flag follows the raw input only after
// FILTER_CYCLES consecutive disagreeing samples, in either direction.
module moisture_filter #(
    parameter int FILTER_CYCLES = 3
) (
    input  logic clk_2,
    input  logic reset,
    input  logic dry_in,
    output logic flag,
    output logic flag_nxt
);
    localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          differ;

    assign differ   = dry_in ^ flag;
    // Exposed so the popcount can update on the same edge as the flag.
    assign flag_nxt = (differ && cnt == CNT_LAST) ? ~flag : flag;

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            flag <= 1'b0;
        end else begin
            flag <= flag_nxt;
            if (!differ || cnt == CNT_LAST)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/soil_moisture_monitor.sv
// N-channel soil dryness monitor: filtered flags, acknowledgeable alarm and a
// scanning seven-segment display. Define SEG_DP_ALARM_EN for a dp alarm blinker.
module soil_moisture_monitor
    import soil_pkg::*;
#(
    parameter int NCH           = 4,
    parameter int FILTER_CYCLES = 3,
    parameter int SCAN_CYCLES   = 2
) (
    input logic clk_2,
    input logic reset,
    soil_moisture_monitor_if.slave bus
);
    localparam int PW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW   = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int CNTW = $clog2(NCH + 1);
    localparam logic [TW-1:0] SCAN_LAST = TW'(SCAN_CYCLES - 1);

    logic [NCH-1:0]  flags, flags_nxt, flags_p1;
    logic [CNTW-1:0] count_r;
    logic            alarm_r;
    logic [7:0]      seg_r, digit;
    logic [PW-1:0]   ptr;
    logic [2:0]      ptr_idx;
    logic [TW-1:0]   scan_tmr;
    logic            any_dry, rise, dp;
    alarm_state_t    alarm_st;
    disp_state_t     disp_st;

    function automatic logic [CNTW-1:0] popcount(input logic [NCH-1:0] f);
        logic [CNTW-1:0] c;
        c = '0;
        for (int i = 0; i < NCH; i++)
            c = c + CNTW'(f[i]);
        return c;
    endfunction

    function automatic logic [PW-1:0] lowest_set(input logic [NCH-1:0] f);
        logic [PW-1:0] r;
        r = '0;
        for (int i = NCH - 1; i >= 0; i--)
            if (f[i]) r = PW'(i);
        return r;
    endfunction

    // Next set flag strictly above p, else wrap to the lowest set flag, else stay.
    function automatic logic [PW-1:0] next_set(input logic [NCH-1:0] f, input logic [PW-1:0] p);
        logic [PW-1:0] r_above, r_low;
        logic          has_above, has_any;
        r_above = p; r_low = p; has_above = 1'b0; has_any = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (f[i]) begin
                r_low   = PW'(i);
                has_any = 1'b1;
                if (i > int'(p)) begin
                    r_above   = PW'(i);
                    has_above = 1'b1;
                end
            end
        end
        return has_above ? r_above : (has_any ? r_low : p);
    endfunction

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        moisture_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filter (
            .clk_2    (clk_2),
            .reset    (reset),
            .dry_in   (bus.dry_in[i]),
            .flag     (flags[i]),
            .flag_nxt (flags_nxt[i])
        );
    end

    assign any_dry = |flags;
    assign rise    = |(flags & ~flags_p1);

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            alarm_st <= OK;
            alarm_r  <= 1'b0;
            flags_p1 <= '0;
            count_r  <= '0;
        end else begin
            flags_p1 <= flags;
            count_r  <= popcount(flags_nxt);
            case (alarm_st)
                OK: if (any_dry) begin
                    alarm_st <= ALARM; alarm_r <= 1'b1;
                end
                ALARM: if (!any_dry) begin
                    alarm_st <= OK; alarm_r <= 1'b0;
                end else if (bus.ack) begin
                    alarm_st <= ACKED; alarm_r <= 1'b0;
                end
                ACKED: if (!any_dry) begin
                    alarm_st <= OK; alarm_r <= 1'b0;
                end else if (rise) begin
                    alarm_st <= ALARM; alarm_r <= 1'b1;
                end
                default: begin
                    alarm_st <= OK; alarm_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef SEG_DP_ALARM_EN
    logic [TW-1:0] blink_tmr;
    logic          blink;

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            blink_tmr <= '0;
            blink     <= 1'b0;
        end else begin
            case (alarm_st)
                ALARM: if (blink_tmr == SCAN_LAST) begin
                    blink     <= ~blink;
                    blink_tmr <= '0;
                end else begin
                    blink_tmr <= blink_tmr + 1'b1;
                end
                ACKED: begin
                    blink     <= 1'b1;
                    blink_tmr <= '0;
                end
                default: begin
                    blink     <= 1'b0;
                    blink_tmr <= '0;
                end
            endcase
        end
    end

    assign dp = blink;
`else
    assign dp = 1'b0;
`endif

    assign ptr_idx = 3'(ptr);
    assign digit   = (disp_st == SHOW) ? SEG_DIGIT[ptr_idx] : SEG_BLANK;

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            disp_st  <= BLANK;
            ptr      <= '0;
            scan_tmr <= '0;
            seg_r    <= SEG_BLANK;
        end else begin
            seg_r <= digit | {dp, 7'b0};
            case (disp_st)
                BLANK: if (any_dry) begin
                    disp_st  <= SHOW;
                    ptr      <= lowest_set(flags);
                    scan_tmr <= '0;
                end
                SHOW: if (!any_dry) begin
                    disp_st  <= BLANK;
                    ptr      <= '0;
                    scan_tmr <= '0;
                end else if (!flags[ptr] || scan_tmr == SCAN_LAST) begin
                    ptr      <= next_set(flags, ptr);
                    scan_tmr <= '0;
                end else begin
                    scan_tmr <= scan_tmr + 1'b1;
                end
                default: disp_st <= BLANK;
            endcase
        end
    end

    assign bus.dry_flags = flags;
    assign bus.dry_count = count_r;
    assign bus.alarm     = alarm_r;
    assign bus.seg       = seg_r;
endmodule

// File: tb/tb_soil_moisture_monitor.sv
// Directed testbench for soil_moisture_monitor (NCH=4, FILTER_CYCLES=3, SCAN_CYCLES=2).
module tb_soil_moisture_monitor;

`ifdef SEG_DP_ALARM_EN
    localparam logic DP_EN = 1'b1;
`else
    localparam logic DP_EN = 1'b0;
`endif

    logic clk_2 = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] scan_exp [5] = '{8'h06, 8'h06, 8'h4F, 8'h4F, 8'h06};
    logic       scan_dp  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    soil_moisture_monitor_if #(.NCH(4)) bus();

    soil_moisture_monitor #(
        .NCH           (4),
        .FILTER_CYCLES (3),
        .SCAN_CYCLES   (2)
    ) dut (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk_2 = ~clk_2;

    task automatic tick();
        @(posedge clk_2);
        #1;
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        bus.dry_in = 4'b0000;
        bus.ack    = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bus.dry_in = 4'b0000;
        bus.ack    = 1'b0;
        #2;
        checks++; if (bus.dry_flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want %b", bus.dry_flags, 4'b0000); end
        checks++; if (bus.dry_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.dry_count); end
        checks++; if (bus.alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %b want 0", bus.alarm); end
        checks++; if (bus.seg !== 8'h00) begin errors++; $display("FAIL reset_seg: got %h want 00", bus.seg); end
    endtask

    task automatic test_filter();
        do_reset();
        bus.dry_in = 4'b0100;
        tick(); tick();
        bus.dry_in = 4'b0000;
        tick();
        checks++; if (bus.dry_flags !== 4'b0000) begin errors++; $display("FAIL glitch_flags: got %b want 0000", bus.dry_flags); end
        tick(); tick();
        checks++; if (bus.dry_flags !== 4'b0000) begin errors++; $display("FAIL glitch_flags_late: got %b want 0000", bus.dry_flags); end
        bus.dry_in = 4'b0100;
        tick(); tick();
        checks++; if (bus.dry_flags !== 4'b0000) begin errors++; $display("FAIL filter_early: got %b want 0000", bus.dry_flags); end
        tick();
        checks++; if (bus.dry_flags !== 4'b0100) begin errors++; $display("FAIL filter_flags: got %b want 0100", bus.dry_flags); end
        checks++; if (bus.dry_count !== 3'd1) begin errors++; $display("FAIL filter_count: got %0d want 1", bus.dry_count); end
        checks++; if (bus.alarm !== 1'b0) begin errors++; $display("FAIL filter_alarm_early: got %b want 0", bus.alarm); end
        tick();
        checks++; if (bus.alarm !== 1'b1) begin errors++; $display("FAIL filter_alarm: got %b want 1", bus.alarm); end
    endtask

    task automatic test_scan();
        logic [7:0] want;
        do_reset();
        bus.dry_in = 4'b1010;
        tick(); tick(); tick();
        checks++; if (bus.dry_flags !== 4'b1010) begin errors++; $display("FAIL scan_flags: got %b want 1010", bus.dry_flags); end
        checks++; if (bus.dry_count !== 3'd2) begin errors++; $display("FAIL scan_count: got %0d want 2", bus.dry_count); end
        tick();
        checks++; if (bus.seg !== 8'h00) begin errors++; $display("FAIL scan_seg_latency: got %h want 00", bus.seg); end
        for (int i = 0; i < 5; i++) begin
            tick();
            want = scan_exp[i] | {(scan_dp[i] & DP_EN), 7'b0};
            checks++; if (bus.seg !== want) begin errors++; $display("FAIL scan_seg[%0d]: got %h want %h", i, bus.seg, want); end
        end
        checks++; if (bus.alarm !== 1'b1) begin errors++; $display("FAIL scan_alarm: got %b want 1", bus.alarm); end
        #3;
        reset = 1'b1;
        #1;
        checks++; if (bus.dry_flags !== 4'b0000) begin errors++; $display("FAIL async_flags: got %b want 0000", bus.dry_flags); end
        checks++; if (bus.dry_count !== 3'd0) begin errors++; $display("FAIL async_count: got %0d want 0", bus.dry_count); end
        checks++; if (bus.alarm !== 1'b0) begin errors++; $display("FAIL async_alarm: got %b want 0", bus.alarm); end
        checks++; if (bus.seg !== 8'h00) begin errors++; $display("FAIL async_seg: got %h want 00", bus.seg); end
    endtask

    task automatic test_ack();
        do_reset();
        bus.ack = 1'b1;
        tick(); tick();
        checks++; if (bus.alarm !== 1'b0) begin errors++; $display("FAIL ack_in_ok: got %b want 0", bus.alarm); end
        bus.ack    = 1'b0;
        bus.dry_in = 4'b0001;
        tick(); tick(); tick();
        checks++; if (bus.dry_flags !== 4'b0001) begin errors++; $display("FAIL ack_flags: got %b want 0001", bus.dry_flags); end
        tick();
        checks++; if (bus.alarm !== 1'b1) begin errors++; $display("FAIL ack_alarm_on: got %b want 1", bus.alarm); end
        bus.ack = 1'b1;
        tick();
        checks++; if (bus.alarm !== 1'b0) begin errors++; $display("FAIL ack_acked: got %b want 0", bus.alarm); end
        tick();
        bus.dry_in = 4'b1001;
        tick(); tick();
        checks++; if (bus.seg[7] !== DP_EN) begin errors++; $display("FAIL ack_dp: got %b want %b", bus.seg[7], DP_EN); end
        tick();
        checks++; if (bus.dry_flags !== 4'b1001) begin errors++; $display("FAIL ack_flag3: got %b want 1001", bus.dry_flags); end
        checks++; if (bus.alarm !== 1'b0) begin errors++; $display("FAIL ack_still_acked: got %b want 0", bus.alarm); end
        tick();
        checks++; if (bus.alarm !== 1'b1) begin errors++; $display("FAIL ack_realarm: got %b want 1", bus.alarm); end
        bus.ack = 1'b0;
        tick();
        checks++; if (bus.alarm !== 1'b1) begin errors++; $display("FAIL ack_realarm_hold: got %b want 1", bus.alarm); end
    endtask

    task automatic test_clear();
        do_reset();
        bus.dry_in = 4'b1010;
        tick(); tick(); tick(); tick(); tick();
        bus.dry_in = 4'b1000;
        tick(); tick(); tick();
        checks++; if (bus.dry_flags !== 4'b1000) begin errors++; $display("FAIL clear_ch1_flags: got %b want 1000", bus.dry_flags); end
        checks++; if (bus.dry_count !== 3'd1) begin errors++; $display("FAIL clear_ch1_count: got %0d want 1", bus.dry_count); end
        tick();
        checks++; if (bus.seg[6:0] !== 7'h06) begin errors++; $display("FAIL clear_seg_before_jump: got %h want 06", bus.seg[6:0]); end
        tick();
        checks++; if (bus.seg[6:0] !== 7'h4F) begin errors++; $display("FAIL clear_ptr_jump: got %h want 4f", bus.seg[6:0]); end
        bus.dry_in = 4'b0000;
        tick(); tick(); tick();
        checks++; if (bus.dry_flags !== 4'b0000) begin errors++; $display("FAIL clear_all_flags: got %b want 0000", bus.dry_flags); end
        checks++; if (bus.dry_count !== 3'd0) begin errors++; $display("FAIL clear_all_count: got %0d want 0", bus.dry_count); end
        tick();
        checks++; if (bus.alarm !== 1'b0) begin errors++; $display("FAIL clear_alarm: got %b want 0", bus.alarm); end
        tick(); tick();
        checks++; if (bus.seg !== 8'h00) begin errors++; $display("FAIL clear_seg: got %h want 00", bus.seg); end
    endtask

    initial begin
        bus.dry_in = 4'b0000;
        bus.ack    = 1'b0;
        test_reset();
        test_filter();
        test_scan();
        test_ack();
        test_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
